id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage that registers decoded instruction fields and presents resolved operands to the `alu_ex` execute ALU. It forwards results from the MEM and WB stages into both ALU operands and the store data, selects the immediate for the second operand, and detects load-use hazards. It inserts one bubble per load-use hazard and supports pipeline hold and branch flush.

## Interface
Parameters: none.

Clock and reset:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: reset, synchronous, active-high.

Inputs from decode:
- `id_valid` in 1: ID holds a valid instruction.
- `id_pc` in 32: instruction PC.
- `id_alu_ctl` in 5: ALU op. `{I/R, funct7[5], funct3}` encoding, as consumed by `alu_ex`.
- `id_rs1_addr`, `id_rs2_addr` in 5: source register indices.
- `id_rs1_used`, `id_rs2_used` in 1: the instruction reads rs1 / rs2.
- `id_rs1_data`, `id_rs2_data` in 32: regfile read data. The regfile is write-first (same-cycle WB write is visible).
- `id_imm` in 32: sign-extended immediate.
- `id_use_imm` in 1: `data1` takes `id_imm` instead of rs2.
- `id_shamt` in 5: immediate shift amount.
- `id_rd_addr` in 5, `id_reg_wr` in 1, `id_mem_rd` in 1, `id_mem_wr` in 1: destination register and control.

Inputs from later stages and hazard control:
- `mem_rd_addr` in 5, `mem_reg_wr` in 1, `mem_result` in 32: EX/MEM ALU result.
- `wb_rd_addr` in 5, `wb_reg_wr` in 1, `wb_result` in 32: MEM/WB writeback value.
- `ex_hold` in 1: freeze EX (memory wait).
- `ex_flush` in 1: kill the instruction entering EX (taken branch or jump).

Outputs:
- `alu_ctl` out 5, `data0` out 32, `data1` out 32, `shamt` out 5: to `alu_ex`.
- `ex_valid` out 1, `ex_pc` out 32, `ex_rd_addr` out 5, `ex_reg_wr` out 1, `ex_mem_rd` out 1, `ex_mem_wr` out 1.
- `ex_store_data` out 32: forwarded rs2 value.
- `id_stall` out 1: IF/ID must hold this cycle.

## Operation
- Registered state: valid, pc, alu_ctl, rs1/rs2 addr and data, rs used flags, imm, use_imm, shamt, rd, reg_wr, mem_rd, mem_wr.

Forwarding (combinational, from registered EX state):
- `fwd1` = `mem_result` if `mem_reg_wr && mem_rd_addr != 0 && mem_rd_addr == ex_rs1_addr`.
- Else `fwd1` = `wb_result` under the same conditions on the WB inputs.
- Else `fwd1` = stored rs1 data.
- MEM has priority over WB. Register x0 is never forwarded.
- `fwd2` is computed the same way for rs2.
- `data0` = `fwd1`; `data1` = `use_imm ? imm : fwd2`; `ex_store_data` = `fwd2`.

Load-use detection:
- `load_use` = `ex_valid && ex_mem_rd && ex_rd_addr != 0 && id_valid && ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr))`.
- `id_stall` = `(load_use || ex_hold) && !ex_flush`.

Next-state priority:
1. `rst`: all registers cleared to 0.
2. `ex_flush`: bubble. valid, reg_wr, mem_rd and mem_wr are set to 0 and alu_ctl to 0 (ADD); other fields are don't-care. Flush wins over hold.
3. `ex_hold`: contents retained, but stored rs1/rs2 data are overwritten with `fwd1`/`fwd2`. This captures a WB value that may retire during the hold.
4. `load_use`: bubble, as for flush. ID is held by `id_stall`.
5. Otherwise: load all fields from the ID inputs. A bubble is loaded if `!id_valid`.
- A bubble never asserts `ex_reg_wr`, `ex_mem_rd` or `ex_mem_wr`.

## Timing
- Reset value of every output is 0. For example, `alu_ctl` = ADD and `data0` = `data1` = 0, so `alu_ex` reports Zero = 1.
- ID→EX latency is 1 cycle. Forwarding adds no cycles.
- A load immediately followed by a dependent instruction costs exactly 1 bubble cycle. The dependent instruction enters EX with the load value forwarded from WB.
- `id_stall` is combinational and valid within the same cycle.
- Reset asserted mid-operation clears state on the next edge, regardless of hold or flush.

## Test plan
- Reset, then `id_valid`, ADD, rs1 = 5 (data 0x10), rs2 = 6 (data 0x20) -> next cycle `alu_ctl` = 0x00, `data0` = 0x10, `data1` = 0x20, `ex_valid` = 1.
- EX rs1 = 3 with `mem_rd_addr` = 3 / `mem_result` = 0xAAAA and `wb_rd_addr` = 3 / `wb_result` = 0xBBBB -> `data0` = 0xAAAA. The same stimulus with rd = 0 on both -> stored data is used.
- Load `lw` x7 in EX, ID `add` reads x7 -> `id_stall` = 1 for one cycle, EX bubble with `ex_reg_wr` = 0. Next cycle the add enters EX and takes `wb_result` on x7.
- `id_use_imm` = 1, `id_imm` = 0xFFFFFFFC, `id_alu_ctl` = I_SRA (0x1D), `id_shamt` = 2 -> `data1` = 0xFFFFFFFC and `shamt` = 2.
- `ex_hold` = 1 for 3 cycles while WB retires x4 = 0x1234 on the hold's first cycle (EX rs1 = x4) -> `data0` = 0x1234 on the release cycle. `ex_flush` asserted together with hold -> bubble, `ex_valid` = 0.
- `ex_flush` asserted in the same cycle as `load_use` -> bubble, `id_stall` = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// One cycle ID->EX; ex_hold freezes EX, and load-use or hold raises id_stall to freeze ID.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [4:0]  id_alu_ctl,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic        id_use_imm,
   input  logic [4:0]  id_shamt,
   input  logic [4:0]  id_rd_addr,
   input  logic        id_reg_wr,
   input  logic        id_mem_rd,
   input  logic        id_mem_wr,
   input  logic [4:0]  mem_rd_addr,
   input  logic        mem_reg_wr,
   input  logic [31:0] mem_result,
   input  logic [4:0]  wb_rd_addr,
   input  logic        wb_reg_wr,
   input  logic [31:0] wb_result,
   input  logic        ex_hold,
   input  logic        ex_flush,
   output logic [4:0]  alu_ctl,
   output logic [31:0] data0,
   output logic [31:0] data1,
   output logic [4:0]  shamt,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [4:0]  ex_rd_addr,
   output logic        ex_reg_wr,
   output logic        ex_mem_rd,
   output logic        ex_mem_wr,
   output logic [31:0] ex_store_data,
   output logic        id_stall
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  alu_ctl;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        use_imm;
      logic [4:0]  shamt;
      logic [4:0]  rd_addr;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
   } ex_state_t;

   ex_state_t   ex_q;
   ex_state_t   ex_d;
   logic [31:0] fwd1;
   logic [31:0] fwd2;
   logic        load_use;

   // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
   always_comb begin
      fwd1 = ex_q.rs1_data;
      if (mem_reg_wr && mem_rd_addr != 5'd0 && mem_rd_addr == ex_q.rs1_addr)
         fwd1 = mem_result;
      else if (wb_reg_wr && wb_rd_addr != 5'd0 && wb_rd_addr == ex_q.rs1_addr)
         fwd1 = wb_result;
      fwd2 = ex_q.rs2_data;
      if (mem_reg_wr && mem_rd_addr != 5'd0 && mem_rd_addr == ex_q.rs2_addr)
         fwd2 = mem_result;
      else if (wb_reg_wr && wb_rd_addr != 5'd0 && wb_rd_addr == ex_q.rs2_addr)
         fwd2 = wb_result;
   end

   assign load_use = ex_q.valid && ex_q.mem_rd && ex_q.rd_addr != 5'd0 && id_valid &&
                     ((id_rs1_used && id_rs1_addr == ex_q.rd_addr) ||
                      (id_rs2_used && id_rs2_addr == ex_q.rd_addr));
   assign id_stall = (load_use || ex_hold) && !ex_flush;

   always_comb begin
      ex_d = ex_q;
      if (ex_flush) begin
         ex_d = '0;
      end else if (ex_hold) begin
         // Refresh operands so a WB value retiring during the hold is not lost.
         ex_d.rs1_data = fwd1;
         ex_d.rs2_data = fwd2;
      end else if (load_use || !id_valid) begin
         ex_d = '0;
      end else begin
         ex_d.valid    = 1'b1;
         ex_d.pc       = id_pc;
         ex_d.alu_ctl  = id_alu_ctl;
         ex_d.rs1_addr = id_rs1_addr;
         ex_d.rs2_addr = id_rs2_addr;
         ex_d.rs1_data = id_rs1_data;
         ex_d.rs2_data = id_rs2_data;
         ex_d.imm      = id_imm;
         ex_d.use_imm  = id_use_imm;
         ex_d.shamt    = id_shamt;
         ex_d.rd_addr  = id_rd_addr;
         ex_d.reg_wr   = id_reg_wr;
         ex_d.mem_rd   = id_mem_rd;
         ex_d.mem_wr   = id_mem_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   assign alu_ctl       = ex_q.alu_ctl;
   assign data0         = fwd1;
   assign data1         = ex_q.use_imm ? ex_q.imm : fwd2;
   assign shamt         = ex_q.shamt;
   assign ex_valid      = ex_q.valid;
   assign ex_pc         = ex_q.pc;
   assign ex_rd_addr    = ex_q.rd_addr;
   assign ex_reg_wr     = ex_q.reg_wr;
   assign ex_mem_rd     = ex_q.mem_rd;
   assign ex_mem_wr     = ex_q.mem_wr;
   assign ex_store_data = fwd2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX contents are queued when ID is driven
// and popped when the stage presents them.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  alu_ctl;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic        rs1_used;
      logic        rs2_used;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        use_imm;
      logic [4:0]  shamt;
      logic [4:0]  rd_addr;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
   } id_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  alu_ctl;
      logic [31:0] data0;
      logic [31:0] data1;
      logic [31:0] store;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
   } out_t;

   typedef struct {
      logic bubble;
      out_t o;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   id_t         idv;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic        mem_reg_wr, wb_reg_wr;
   logic [31:0] mem_result, wb_result;
   logic        ex_hold, ex_flush;

   logic [4:0]  alu_ctl, shamt, ex_rd_addr;
   logic [31:0] data0, data1, ex_pc, ex_store_data;
   logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, id_stall;

   out_t        obs;
   logic [8:0]  obs_bub;
   sb_t         sb_q[$];
   sb_t         e;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(idv.valid), .id_pc(idv.pc), .id_alu_ctl(idv.alu_ctl),
      .id_rs1_addr(idv.rs1_addr), .id_rs2_addr(idv.rs2_addr),
      .id_rs1_used(idv.rs1_used), .id_rs2_used(idv.rs2_used),
      .id_rs1_data(idv.rs1_data), .id_rs2_data(idv.rs2_data),
      .id_imm(idv.imm), .id_use_imm(idv.use_imm), .id_shamt(idv.shamt),
      .id_rd_addr(idv.rd_addr), .id_reg_wr(idv.reg_wr), .id_mem_rd(idv.mem_rd), .id_mem_wr(idv.mem_wr),
      .mem_rd_addr(mem_rd_addr), .mem_reg_wr(mem_reg_wr), .mem_result(mem_result),
      .wb_rd_addr(wb_rd_addr), .wb_reg_wr(wb_reg_wr), .wb_result(wb_result),
      .ex_hold(ex_hold), .ex_flush(ex_flush),
      .alu_ctl(alu_ctl), .data0(data0), .data1(data1), .shamt(shamt),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data),
      .id_stall(id_stall)
   );

   assign obs = {ex_valid, ex_pc, alu_ctl, data0, data1, ex_store_data, shamt,
                 ex_rd_addr, ex_reg_wr, ex_mem_rd, ex_mem_wr};
   assign obs_bub = {ex_valid, alu_ctl, ex_reg_wr, ex_mem_rd, ex_mem_wr};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_fwd();
      mem_rd_addr = 5'd0; mem_reg_wr = 1'b0; mem_result = 32'h0;
      wb_rd_addr  = 5'd0; wb_reg_wr  = 1'b0; wb_result  = 32'h0;
   endtask

   function automatic id_t mk_id(logic [31:0] pc, logic [4:0] ctl, logic [4:0] r1, logic [31:0] d1,
                                 logic [4:0] r2, logic [31:0] d2, logic [4:0] rd);
      id_t i;
      i = '0;
      i.valid = 1'b1; i.pc = pc; i.alu_ctl = ctl;
      i.rs1_addr = r1; i.rs1_data = d1; i.rs1_used = 1'b1;
      i.rs2_addr = r2; i.rs2_data = d2; i.rs2_used = 1'b1;
      i.rd_addr = rd; i.reg_wr = 1'b1;
      return i;
   endfunction

   // Expected EX view of instruction i, given the operand values it should resolve to.
   function automatic out_t exp_of(id_t i, logic [31:0] op1, logic [31:0] op2);
      out_t o;
      o.valid = 1'b1; o.pc = i.pc; o.alu_ctl = i.alu_ctl;
      o.data0 = op1; o.data1 = i.use_imm ? i.imm : op2; o.store = op2;
      o.shamt = i.shamt; o.rd = i.rd_addr;
      o.reg_wr = i.reg_wr; o.mem_rd = i.mem_rd; o.mem_wr = i.mem_wr;
      return o;
   endfunction

   function automatic sb_t mk_sb(logic bub, out_t o);
      sb_t s;
      s.bubble = bub; s.o = o;
      return s;
   endfunction

   task automatic test_reset();
      rst = 1'b1; idv = '0; ex_hold = 1'b0; ex_flush = 1'b0; clr_fwd();
      sb_q.push_back(mk_sb(1'b0, '0));
      tick(); tick();
      e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL reset_outputs got %h want %h", obs, e.o); end
      checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", id_stall); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      idv = mk_id(32'h100, 5'h00, 5'd5, 32'h10, 5'd6, 32'h20, 5'd8);
      sb_q.push_back(mk_sb(1'b0, exp_of(idv, 32'h10, 32'h20)));
      tick();
      idv.valid = 1'b0;
      e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL basic_add got %h want %h", obs, e.o); end
   endtask

   task automatic test_forward();
      id_t i;
      i = mk_id(32'h140, 5'h00, 5'd3, 32'h1111, 5'd9, 32'h2222, 5'd10);
      idv = i;
      tick();
      idv = '0;
      mem_rd_addr = 5'd3; mem_reg_wr = 1'b1; mem_result = 32'hAAAA;
      wb_rd_addr  = 5'd3; wb_reg_wr  = 1'b1; wb_result  = 32'hBBBB;
      sb_q.push_back(mk_sb(1'b0, exp_of(i, 32'hAAAA, 32'h2222)));
      #1; e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL fwd_mem_prio got %h want %h", obs, e.o); end
      mem_reg_wr = 1'b0;
      sb_q.push_back(mk_sb(1'b0, exp_of(i, 32'hBBBB, 32'h2222)));
      #1; e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL fwd_wb got %h want %h", obs, e.o); end
      mem_reg_wr = 1'b1; mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
      sb_q.push_back(mk_sb(1'b0, exp_of(i, 32'h1111, 32'h2222)));
      #1; e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL fwd_x0 got %h want %h", obs, e.o); end
      mem_rd_addr = 5'd0; wb_rd_addr = 5'd9; wb_result = 32'hCAFE;
      sb_q.push_back(mk_sb(1'b0, exp_of(i, 32'h1111, 32'hCAFE)));
      #1; e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL fwd_rs2_store got %h want %h", obs, e.o); end
      clr_fwd();
   endtask

   task automatic test_load_use();
      id_t lw, add;
      lw = mk_id(32'h200, 5'h00, 5'd2, 32'h1000, 5'd0, 32'h0, 5'd7);
      lw.rs2_used = 1'b0; lw.use_imm = 1'b1; lw.imm = 32'h4; lw.mem_rd = 1'b1;
      idv = lw;
      sb_q.push_back(mk_sb(1'b0, exp_of(lw, 32'h1000, 32'h0)));
      tick();
      e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL lu_load got %h want %h", obs, e.o); end
      add = mk_id(32'h204, 5'h00, 5'd7, 32'hDEAD, 5'd1, 32'h5, 5'd9);
      idv = add;
      #1; checks++;
      if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", id_stall); end
      sb_q.push_back(mk_sb(1'b1, '0));
      tick();
      e = sb_q.pop_front(); checks++;
      if (obs_bub !== 9'd0) begin errors++; $display("FAIL lu_bubble got %h want 0", obs_bub); end
      checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_unstall got %b want 0", id_stall); end
      sb_q.push_back(mk_sb(1'b0, exp_of(add, 32'h5555, 32'h5)));
      tick();
      wb_rd_addr = 5'd7; wb_reg_wr = 1'b1; wb_result = 32'h5555;
      #1; e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL lu_dep_fwd got %h want %h", obs, e.o); end
      clr_fwd(); idv = '0;
   endtask

   task automatic test_imm();
      idv = mk_id(32'h300, 5'h1D, 5'd1, 32'h80000000, 5'd2, 32'h77, 5'd3);
      idv.use_imm = 1'b1; idv.imm = 32'hFFFFFFFC; idv.shamt = 5'd2; idv.rs2_used = 1'b0;
      sb_q.push_back(mk_sb(1'b0, exp_of(idv, 32'h80000000, 32'h77)));
      tick();
      idv = '0;
      e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL imm_sra got %h want %h", obs, e.o); end
   endtask

   task automatic test_hold();
      id_t a, b;
      a = mk_id(32'h400, 5'h00, 5'd4, 32'h0, 5'd5, 32'h9, 5'd6);
      b = mk_id(32'h404, 5'h08, 5'd11, 32'h30, 5'd12, 32'h40, 5'd13);
      idv = a;
      tick();
      idv = b; ex_hold = 1'b1;
      wb_rd_addr = 5'd4; wb_reg_wr = 1'b1; wb_result = 32'h1234;
      sb_q.push_back(mk_sb(1'b0, exp_of(a, 32'h1234, 32'h9)));
      #1; checks++;
      if (id_stall !== 1'b1) begin errors++; $display("FAIL hold_stall got %b want 1", id_stall); end
      tick();
      clr_fwd(); wb_result = 32'hFFFF;
      tick(); tick();
      ex_hold = 1'b0;
      #1; e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL hold_release got %h want %h", obs, e.o); end
      sb_q.push_back(mk_sb(1'b0, exp_of(b, 32'h30, 32'h40)));
      tick();
      e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL hold_next got %h want %h", obs, e.o); end
   endtask

   task automatic test_flush_hold();
      idv = mk_id(32'h500, 5'h00, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
      ex_hold = 1'b1; ex_flush = 1'b1;
      #1; checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_hold_stall got %b want 0", id_stall); end
      sb_q.push_back(mk_sb(1'b1, '0));
      tick();
      ex_hold = 1'b0; ex_flush = 1'b0; idv = '0;
      e = sb_q.pop_front(); checks++;
      if (obs_bub !== 9'd0) begin errors++; $display("FAIL flush_hold_bubble got %h want 0", obs_bub); end
   endtask

   task automatic test_flush_load_use();
      id_t lw, add;
      lw = mk_id(32'h600, 5'h00, 5'd2, 32'h800, 5'd0, 32'h0, 5'd7);
      lw.mem_rd = 1'b1; lw.rs2_used = 1'b0; lw.use_imm = 1'b1; lw.imm = 32'h8;
      idv = lw;
      tick();
      add = mk_id(32'h604, 5'h00, 5'd1, 32'h3, 5'd7, 32'h4, 5'd8);
      idv = add; ex_flush = 1'b1;
      #1; checks++;
      if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_lu_stall got %b want 0", id_stall); end
      sb_q.push_back(mk_sb(1'b1, '0));
      tick();
      ex_flush = 1'b0;
      e = sb_q.pop_front(); checks++;
      if (obs_bub !== 9'd0) begin errors++; $display("FAIL flush_lu_bubble got %h want 0", obs_bub); end
      sb_q.push_back(mk_sb(1'b0, exp_of(add, 32'h3, 32'h4)));
      tick();
      idv = '0;
      e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL flush_lu_after got %h want %h", obs, e.o); end
   endtask

   task automatic test_back_to_back();
      id_t i;
      for (int k = 0; k < 6; k++) begin
         i = mk_id(32'h700 + 32'(k * 4), 5'(k), 5'(k + 1), $urandom, 5'(k + 10), $urandom, 5'(k + 20));
         i.mem_wr = k[0];
         i.reg_wr = ~k[0];
         idv = i;
         sb_q.push_back(mk_sb(1'b0, exp_of(i, i.rs1_data, i.rs2_data)));
         tick();
         e = sb_q.pop_front(); checks++;
         if (obs !== e.o) begin errors++; $display("FAIL b2b_%0d got %h want %h", k, obs, e.o); end
      end
      idv = '0;
      sb_q.push_back(mk_sb(1'b1, '0));
      tick();
      e = sb_q.pop_front(); checks++;
      if (obs_bub !== 9'd0) begin errors++; $display("FAIL invalid_bubble got %h want 0", obs_bub); end
   endtask

   task automatic test_reset_mid();
      idv = mk_id(32'h800, 5'h07, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3);
      tick();
      rst = 1'b1; ex_hold = 1'b1; ex_flush = 1'b1;
      sb_q.push_back(mk_sb(1'b0, '0));
      tick();
      e = sb_q.pop_front(); checks++;
      if (obs !== e.o) begin errors++; $display("FAIL reset_mid got %h want %h", obs, e.o); end
      rst = 1'b0; ex_hold = 1'b0; ex_flush = 1'b0; idv = '0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_forward();
      test_load_use();
      test_imm();
      test_hold();
      test_flush_hold();
      test_flush_load_use();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
